// File: rtl/tick_sched.sv
// rtl/tick_sched.sv - shared prescaler driving four programmable clock-enable channels
//
// One free-running prescaler produces base_tick every BASE_DIV enabled cycles.
// Four channels each count base ticks and emit a one-cycle tick after div_reg of
// them. Divisors are written through a valid/ready port that accepts at most one
// write every two cycles.
//
// Ports:
//   clk        global clock, rising edge
//   rst        asynchronous reset, active-high
//   base_en    prescaler run enable
//   cfg_valid  config write request
//   cfg_ready  config port can accept (low for one cycle after each accept)
//   cfg_ch     target channel of the write
//   cfg_div    divisor in base ticks; 0 disables the channel
//   base_tick  one-cycle pulse per BASE_DIV enabled cycles
//   tick       per-channel one-cycle enable pulses
//   busy       per-channel state != OFF
module tick_sched #(
    parameter int BASE_DIV = 50000,
    parameter int DIV_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             base_en,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [1:0]       cfg_ch,
    input  logic [DIV_W-1:0] cfg_div,
    output logic             base_tick,
    output logic [3:0]       tick,
    output logic [3:0]       busy
);

    localparam int PRE_W = $clog2(BASE_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(BASE_DIV - 1);

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } ch_state_t;

    logic [PRE_W-1:0] pre_cnt;
    logic             pre_wrap;

    ch_state_t        state_q [4];
    ch_state_t        state_d [4];
    logic [DIV_W-1:0] div_q   [4];
    logic [DIV_W-1:0] div_d   [4];
    logic [DIV_W-1:0] pend_q  [4];
    logic [DIV_W-1:0] pend_d  [4];
    logic [DIV_W-1:0] cnt_q   [4];
    logic [DIV_W-1:0] cnt_d   [4];
    logic [3:0]       tick_d;

    logic             accept;
    logic             div_zero;
    logic [3:0]       wr_sel;

    assign pre_wrap = base_en && (pre_cnt == PRE_LAST);
    assign accept   = cfg_valid && cfg_ready;
    assign div_zero = (cfg_div == '0);
    assign wr_sel   = accept ? (4'b0001 << cfg_ch) : 4'b0000;

    // Prescaler, base_tick register and the config-port throttle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt   <= '0;
            base_tick <= 1'b0;
            cfg_ready <= 1'b1;
        end else begin
            if (base_en) begin
                pre_cnt <= pre_wrap ? '0 : pre_cnt + 1'b1;
            end
            base_tick <= pre_wrap;
            // Drop ready for exactly the cycle after an accept.
            cfg_ready <= !accept;
        end
    end

    // Channel state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < 4; c++) begin
                state_q[c] <= OFF;
                div_q[c]   <= '0;
                pend_q[c]  <= '0;
                cnt_q[c]   <= '0;
            end
            tick <= 4'b0000;
        end else begin
            for (int c = 0; c < 4; c++) begin
                state_q[c] <= state_d[c];
                div_q[c]   <= div_d[c];
                pend_q[c]  <= pend_d[c];
                cnt_q[c]   <= cnt_d[c];
            end
            tick <= tick_d;
        end
    end

    // Channel next-state logic.
    always_comb begin
        tick_d = 4'b0000;
        for (int c = 0; c < 4; c++) begin
            state_d[c] = state_q[c];
            div_d[c]   = div_q[c];
            pend_d[c]  = pend_q[c];
            cnt_d[c]   = cnt_q[c];

            if (state_q[c] == OFF) begin
                // A base_tick on the enabling edge is deliberately not counted.
                if (wr_sel[c] && !div_zero) begin
                    div_d[c]   = cfg_div;
                    cnt_d[c]   = '0;
                    state_d[c] = RUN;
                end
            end else if (wr_sel[c] && div_zero) begin
                // Disable wins over a period completing on the same edge.
                state_d[c] = OFF;
                cnt_d[c]   = '0;
            end else if (base_tick && (cnt_q[c] == div_q[c] - 1'b1)) begin
                tick_d[c] = 1'b1;
                cnt_d[c]  = '0;
                if (wr_sel[c]) begin
                    // New divisor lands exactly at the period boundary.
                    div_d[c]   = cfg_div;
                    state_d[c] = RUN;
                end else if (state_q[c] == PEND) begin
                    div_d[c]   = pend_q[c];
                    state_d[c] = RUN;
                end
            end else begin
                if (base_tick) begin
                    cnt_d[c] = cnt_q[c] + 1'b1;
                end
                if (wr_sel[c]) begin
                    pend_d[c]  = cfg_div;
                    state_d[c] = PEND;
                end
            end
        end
    end

    always_comb begin
        busy = 4'b0000;
        for (int c = 0; c < 4; c++) begin
            busy[c] = (state_q[c] != OFF);
        end
    end

endmodule

// File: doc/tick_sched.md
Name: tick_sched

Overview:
- Shared clock-enable scheduler. One free-running prescaler is time-shared by 4 independent channels, and each channel emits single-cycle enable pulses at a programmable multiple of the base period.
- Replaces derived/ripple clocks in the design: the display scan, debounce and 1-second logic consume tick[] as synchronous enables on the single global clock.
- Channel divisors are reconfigured at run time through a valid/ready write port.

Parameters:
- BASE_DIV, 50000, prescaler length in clk cycles per base tick (≥2).
- DIV_W, 16, width of per-channel divisor in base ticks.

Ports:
- clk  input  1  global clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- base_en  input  1  prescaler run enable.
- cfg_valid  input  1  config write request.
- cfg_ready  output  1  config port can accept.
- cfg_ch  input  2  target channel.
- cfg_div  input  DIV_W  divisor in base ticks; 0 = disable channel.
- base_tick  output  1  one-cycle pulse per BASE_DIV enabled cycles.
- tick  output  4  per-channel one-cycle enable pulses.
- busy  output  4  channel state != OFF.

Behaviour:
- Reset (async, any time): pre_cnt=0, all channels OFF, div/pend/cnt=0. Outputs: base_tick=0, tick=0, busy=0, cfg_ready=1. Pending writes are discarded.
- Prescaler: pre_cnt increments only while base_en=1 and wraps at BASE_DIV-1. base_tick is registered and high for exactly the cycle after the wrap cycle. The first base_tick comes BASE_DIV cycles after base_en first samples 1. With base_en=0, pre_cnt holds and no base_tick is produced.
- Config handshake:
  - A transfer is accepted on a clk edge where cfg_valid=1 and cfg_ready=1.
  - cfg_ready drops to 0 for exactly one cycle after each accept, so the port accepts at most one write every 2 cycles.
  - cfg_ch, cfg_div are sampled only at the accept edge.
- Channel FSM (per channel; states OFF, RUN, PEND):
  - OFF + write div≠0: div_reg=div, cnt=0, go to RUN.
  - OFF + write div=0: stay OFF.
  - RUN/PEND + write div=0: go to OFF, cnt=0, and suppress any tick from that same edge (disable wins).
  - RUN + write div≠0: pend_reg=div, go to PEND.
  - PEND + write div≠0: overwrite pend_reg.
  - RUN/PEND on base_tick: if cnt==div_reg-1, set tick[c]=1 next cycle and cnt=0. In PEND, also set div_reg=pend_reg and return to RUN. Otherwise cnt++.
  - Period completion on the same edge as a div≠0 write: tick is emitted, div_reg=new div, cnt=0, state RUN (PEND is skipped).
  - OFF write on the same edge as base_tick: that base_tick is not counted.
- Timing: steady-state tick period is div_reg × BASE_DIV cycles. tick[c] lags its causing base_tick by 1 cycle.
- Width rules:
  - div=1 gives a tick on every base_tick.
  - cnt is DIV_W bits wide and never exceeds div_reg-1.
  - div=2^DIV_W-1 is legal; there is no overflow path.
- Multiple channels may tick in the same cycle; there is no arbitration between channels.
- busy is registered and reflects the state after the edge.

Test Plan:
- BASE_DIV=4. Release rst, base_en=1, write ch0 div=3 → base_tick every 4 cycles; tick[0] every 12 cycles; busy=4'b0001; cfg_ready low exactly 1 cycle after the accept.
- ch0 running div=3, write div=5 mid-period → current period completes at 12 cycles; subsequent ticks every 20 cycles; busy stays 1.
- ch1 div=2. Write div=0 on the cycle of its completing base_tick → no tick[1] pulse; busy[1]=0 next cycle.
- All 4 channels div=1, base_en toggled 0 for 10 cycles → all tick bits pulse together once per base_tick; no pulses while base_en=0; phase resumes without loss.
- cfg_valid held high with back-to-back writes to ch0..ch3 → accepts on alternating cycles only; all four channels become busy after 8 cycles.
- Assert rst mid-period with ch2 in PEND → outputs zero immediately (async); after release, ch2 is OFF and no tick occurs until rewritten.
